hex_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for the SLC-3 top level. It replaces the fixed 4-digit `hex_seg`/`hex_grid` drivers with one block that supports a configurable digit count, refresh rate and output polarity. It also adds per-digit decimal points, leading-zero blanking, an enable/blank mode, and tear-free double-buffered updates. Two instances drive the A and B display banks, fed from `hex_4`/register taps.

---
 rtl/hex_pkg.sv | 24 ++
 rtl/hex_seg_decoder.sv | 20 ++
 rtl/hex_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_hex_scan_driver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_pkg.sv
// -----------------------------------------------------------------------------
// hex_pkg
// Shared constants and helpers for the seven-segment scan driver.
//   SEG_PATTERNS  : 16-entry active-high {g,f,e,d,c,b,a} patterns for hex 0-F
//   SEG_OFF       : active-high "all segments off" pattern (dp included)
//   seg_polarity  : applies output polarity to an active-high 8-bit pattern
// -----------------------------------------------------------------------------
package hex_pkg;

   localparam logic [6:0] SEG_PATTERNS [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   localparam logic [7:0] SEG_OFF = 8'h00;

   function automatic logic [7:0] seg_polarity(input logic [7:0] pattern,
                                               input logic       active_low);
      return active_low ? ~pattern : pattern;
   endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// -----------------------------------------------------------------------------
// hex_seg_decoder
// Combinational hex nibble + decimal point to active-high segment pattern.
//   nibble_i  [3:0] : hex value to display
//   dp_i            : decimal point request
//   pattern_o [7:0] : {dp, g, f, e, d, c, b, a}, active-high
// -----------------------------------------------------------------------------
module hex_seg_decoder
   import hex_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       dp_i,
   output logic [7:0] pattern_o
);

   always_comb begin
      pattern_o = {dp_i, SEG_PATTERNS[nibble_i]};
   end

endmodule

// File: rtl/hex_scan_driver.sv
// -----------------------------------------------------------------------------
// hex_scan_driver
// Time-multiplexed seven-segment controller with double-buffered digits,
// per-digit decimal points, leading-zero blanking and enable/blank mode.
//   Clk         : system clock
//   Reset       : synchronous, active-low
//   digits_in   : nibble per digit, digit 0 in [3:0] (rightmost)
//   dp_in       : decimal point per digit
//   load        : capture digits_in/dp_in into the pending buffer
//   blank_lz    : leading-zero blanking enable
//   enable      : 0 blanks the display and freezes the scan
//   hex_seg     : {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   hex_grid    : one-hot digit select, polarity per GRID_ACTIVE_LOW
//   frame_done  : one-cycle pulse after the scan wraps to digit 0
// -----------------------------------------------------------------------------
module hex_scan_driver
   import hex_pkg::*;
#(
   parameter int unsigned NUM_DIGITS      = 4,
   parameter int unsigned REFRESH_DIV     = 50000,
   parameter bit          SEG_ACTIVE_LOW  = 1'b1,
   parameter bit          GRID_ACTIVE_LOW = 1'b1
)(
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [7:0]              hex_seg,
   output logic [NUM_DIGITS-1:0]   hex_grid,
   output logic                    frame_done
);

   localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] GRID_OFF = GRID_ACTIVE_LOW ? '1 : '0;

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic                    pend_vld_q, pend_vld_d;
   logic [7:0]              seg_q;
   logic [NUM_DIGITS-1:0]   grid_q;
   logic                    frame_q;

   logic                    wrap;
   logic [3:0]              sel_nib;
   logic                    sel_dp;
   logic                    sel_blank;
   logic [NUM_DIGITS-1:0]   blank_vec;
   logic                    zero_run;
   logic [NUM_DIGITS-1:0]   grid_onehot;
   logic [7:0]              dec_pat;
   logic [7:0]              seg_pat;

   // Divider, index and double buffer
   always_comb begin
      div_d      = div_q;
      idx_d      = idx_q;
      wrap       = 1'b0;
      act_dig_d  = act_dig_q;
      act_dp_d   = act_dp_q;
      pend_dig_d = pend_dig_q;
      pend_dp_d  = pend_dp_q;
      pend_vld_d = pend_vld_q;

      if (enable) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               wrap  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      if (wrap && pend_vld_q) begin
         act_dig_d  = pend_dig_q;
         act_dp_d   = pend_dp_q;
         pend_vld_d = 1'b0;
      end

      // A load on the wrap cycle refills pending after the transfer above,
      // so the new value waits for the following wrap.
      if (load) begin
         pend_dig_d = digits_in;
         pend_dp_d  = dp_in;
         pend_vld_d = 1'b1;
      end
   end

   // Leading-zero blanking: walk down from the top digit while digits are zero
   always_comb begin
      blank_vec = '0;
      zero_run  = blank_lz;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (act_dig_q[4*i +: 4] == 4'h0);
         blank_vec[i] = zero_run;
      end
   end

   // Digit select and one-hot grid
   always_comb begin
      sel_nib     = 4'h0;
      sel_dp      = 1'b0;
      sel_blank   = 1'b0;
      grid_onehot = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            sel_nib        = act_dig_q[4*i +: 4];
            sel_dp         = act_dp_q[i];
            sel_blank      = blank_vec[i];
            grid_onehot[i] = 1'b1;
         end
      end
   end

   hex_seg_decoder u_dec (
      .nibble_i  (sel_nib),
      .dp_i      (sel_dp),
      .pattern_o (dec_pat)
   );

   always_comb begin
      seg_pat = sel_blank ? (SEG_OFF | {sel_dp, 7'h00}) : dec_pat;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         div_q      <= '0;
         idx_q      <= '0;
         act_dig_q  <= '0;
         act_dp_q   <= '0;
         pend_dig_q <= '0;
         pend_dp_q  <= '0;
         pend_vld_q <= 1'b0;
         seg_q      <= seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
         grid_q     <= GRID_OFF;
         frame_q    <= 1'b0;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         act_dig_q  <= act_dig_d;
         act_dp_q   <= act_dp_d;
         pend_dig_q <= pend_dig_d;
         pend_dp_q  <= pend_dp_d;
         pend_vld_q <= pend_vld_d;
         seg_q      <= enable ? seg_polarity(seg_pat, SEG_ACTIVE_LOW)
                              : seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
         grid_q     <= enable ? (GRID_ACTIVE_LOW ? ~grid_onehot : grid_onehot)
                              : GRID_OFF;
         frame_q    <= wrap;
      end
   end

   assign hex_seg    = seg_q;
   assign hex_grid   = grid_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_driver
// Self-checking bench for hex_scan_driver (4 digits, 4-cycle refresh,
// active-low segments and grid) against a frame-position reference model.
// -----------------------------------------------------------------------------
module tb_hex_scan_driver;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        load;
   logic        blank_lz;
   logic        enable;
   logic [7:0]  hex_seg;
   logic [3:0]  hex_grid;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;

   // Active-low segment images of 0-F with dp off
   logic [7:0] seg_lut [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Reference model: position within a 16-cycle frame plus two buffers
   int          pos;
   logic [15:0] m_act, m_pend;
   logic [3:0]  m_adp, m_pdp;
   bit          m_pv;

   hex_scan_driver #(
      .NUM_DIGITS      (4),
      .REFRESH_DIV     (4),
      .SEG_ACTIVE_LOW  (1'b1),
      .GRID_ACTIVE_LOW (1'b1)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .enable     (enable),
      .hex_seg    (hex_seg),
      .hex_grid   (hex_grid),
      .frame_done (frame_done)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // One clock: predict outputs from pre-edge state, clock, compare, advance model
   task automatic step();
      logic [7:0] es;
      logic [3:0] eg;
      logic       ef;
      logic       wrap;
      int         d;
      es   = 8'hFF;
      eg   = 4'hF;
      ef   = 1'b0;
      wrap = 1'b0;
      if (Reset) begin
         d    = pos / 4;
         wrap = enable && (pos == 15);
         ef   = wrap;
         if (enable) begin
            eg    = 4'hF;
            eg[d] = 1'b0;
            if (blank_lz && d > 0 && (m_act >> (4*d)) == 16'h0)
               es = 8'hFF;
            else
               es = seg_lut[m_act[4*d +: 4]];
            if (m_adp[d]) es[7] = 1'b0;
         end
      end

      @(posedge Clk);
      #1;
      check_eq("hex_seg",    {24'h0, hex_seg},  {24'h0, es});
      check_eq("hex_grid",   {28'h0, hex_grid}, {28'h0, eg});
      check_eq("frame_done", {31'h0, frame_done}, {31'h0, ef});

      if (!Reset) begin
         pos    = 0;
         m_act  = '0;
         m_adp  = '0;
         m_pend = '0;
         m_pdp  = '0;
         m_pv   = 1'b0;
      end else begin
         if (enable) pos = (pos + 1) % 16;
         if (wrap && m_pv) begin
            m_act = m_pend;
            m_adp = m_pdp;
            m_pv  = 1'b0;
         end
         if (load) begin
            m_pend = digits_in;
            m_pdp  = dp_in;
            m_pv   = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Step until the model reaches frame position p (bounded)
   task automatic wait_pos(input int p);
      int guard;
      guard = 0;
      while (pos != p && guard < 40) begin
         step();
         guard++;
      end
      if (pos != p) check_eq("wait_pos_timeout", pos, p);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      digits_in = v;
      dp_in     = dp;
      load      = 1'b1;
      step();
      load      = 1'b0;
   endtask

   initial begin
      Reset     = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      load      = 1'b0;
      blank_lz  = 1'b0;
      enable    = 1'b0;
      pos       = 0;
      m_act     = '0;
      m_adp     = '0;
      m_pend    = '0;
      m_pdp     = '0;
      m_pv      = 1'b0;

      // Reset held for 3 cycles
      run(3);
      check_eq("reset_seg", {24'h0, hex_seg}, 32'hFF);
      Reset = 1'b1;

      // Basic scan of 0B21
      do_load(16'h0B21, 4'b0000);
      enable = 1'b1;
      run(40);

      // Leading-zero blanking, then dp on a blanked digit
      blank_lz = 1'b1;
      do_load(16'h000B, 4'b0000);
      run(36);
      do_load(16'h000B, 4'b0100);
      run(36);
      blank_lz = 1'b0;

      // Tear-free: load during digit 2, then load exactly on the wrap cycle
      wait_pos(9);
      do_load(16'h1234, 4'b0000);
      run(36);
      wait_pos(15);
      do_load(16'h5678, 4'b0001);
      run(40);

      // Disable mid-digit-1 and resume
      wait_pos(5);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      run(20);

      // Mid-frame reset with a pending value
      wait_pos(12);
      do_load(16'hABCD, 4'b1010);
      Reset = 1'b0;
      run(2);
      Reset = 1'b1;
      run(20);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] v;
         for (int k = 0; k < 4; k++)
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         digits_in = v;
         dp_in     = 4'($urandom);
         load      = ($urandom_range(0, 5) == 0);
         enable    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
         Reset     = ($urandom_range(0, 299) != 0);
         step();
      end
      Reset = 1'b1;
      load  = 1'b0;
      run(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
